// File: rtl/instr_fetcher.sv
// rtl/instr_fetcher.sv - single-issue instruction fetcher between memory controller and decoder
// Optional direct-mapped one-word-per-line i-cache enabled by FETCHER_ICACHE_EN.
module instr_fetcher #(
    parameter logic [31:0] RESET_PC           = 32'h0,
    parameter int          ICACHE_INDEX_WIDTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_data,
    input  logic        rob_full,
    input  logic        rs_full,
    input  logic        lsb_full,
    output logic        instr_ready,
    output logic [31:0] instr_out,
    output logic [31:0] instr_addr_out,
    input  logic        instr_issued,
    input  logic [31:0] predict_pc,
    input  logic        rob_clear,
    input  logic [31:0] rob_new_pc
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_WAIT_MEM,
        S_HOLD,
        S_WAIT_PC,
        S_DISCARD
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] iaddr_q, iaddr_d;
    logic        mem_req_q, mem_req_d;
    logic        ready_q, ready_d;
    logic        accept;
    logic        hit;
    logic [31:0] hit_data;
    logic        fill;

    // Same condition the decoder uses to consume, so each word is taken exactly once.
    assign accept = ready_q & ~rob_full & ~rs_full & ~lsb_full;

`ifdef FETCHER_ICACHE_EN
    localparam int LINES = 1 << ICACHE_INDEX_WIDTH;
    localparam int TAG_W = 30 - ICACHE_INDEX_WIDTH;

    logic [LINES-1:0]              valid_q;
    logic [31:0]                   data_q [LINES];
    logic [TAG_W-1:0]              tag_q  [LINES];
    logic [ICACHE_INDEX_WIDTH-1:0] idx;
    logic [TAG_W-1:0]              tag;

    assign idx      = pc_q[ICACHE_INDEX_WIDTH+1:2];
    assign tag      = pc_q[31:ICACHE_INDEX_WIDTH+2];
    assign hit      = valid_q[idx] && (tag_q[idx] == tag);
    assign hit_data = data_q[idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (rdy && fill) begin
            valid_q[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && rdy && fill) begin
            data_q[idx] <= mem_data;
            tag_q[idx]  <= tag;
        end
    end
`else
    logic [32:0] unused_icache;

    assign hit           = 1'b0;
    assign hit_data      = '0;
    assign unused_icache = {fill, 32'(ICACHE_INDEX_WIDTH)};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else if (rdy) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (rob_clear) begin
            // A read still in flight must have its response absorbed before refetching.
            state_d = (state_q == S_WAIT_MEM && !mem_ready) ? S_DISCARD : S_FETCH;
        end else begin
            case (state_q)
                S_FETCH:    state_d = hit ? S_HOLD : S_WAIT_MEM;
                S_WAIT_MEM: if (mem_ready) state_d = S_HOLD;
                S_HOLD:     if (accept) state_d = S_WAIT_PC;
                S_WAIT_PC:  if (instr_issued) state_d = S_FETCH;
                S_DISCARD:  if (mem_ready) state_d = S_FETCH;
                default:    state_d = S_FETCH;
            endcase
        end
    end

    always_comb begin
        pc_d       = pc_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        ready_d    = ready_q;
        instr_d    = instr_q;
        iaddr_d    = iaddr_q;
        fill       = 1'b0;
        if (rob_clear) begin
            pc_d      = rob_new_pc;
            ready_d   = 1'b0;
            mem_req_d = 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (hit) begin
                        instr_d = hit_data;
                        iaddr_d = pc_q;
                        ready_d = 1'b1;
                    end else begin
                        mem_req_d  = 1'b1;
                        mem_addr_d = {pc_q[31:2], 2'b00};
                    end
                end
                S_WAIT_MEM: begin
                    if (mem_ready) begin
                        instr_d   = mem_data;
                        iaddr_d   = pc_q;
                        ready_d   = 1'b1;
                        mem_req_d = 1'b0;
                        fill      = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (accept) ready_d = 1'b0;
                end
                S_WAIT_PC: begin
                    if (instr_issued) pc_d = predict_pc;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            ready_q    <= 1'b0;
            instr_q    <= '0;
            iaddr_q    <= '0;
        end else if (rdy) begin
            pc_q       <= pc_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            ready_q    <= ready_d;
            instr_q    <= instr_d;
            iaddr_q    <= iaddr_d;
        end
    end

    assign mem_req        = mem_req_q;
    assign mem_addr       = mem_addr_q;
    assign instr_ready    = ready_q;
    assign instr_out      = instr_q;
    assign instr_addr_out = iaddr_q;

endmodule
